univ_shift_reg: RTL and testbench

Parametrised universal shift register with a saturating shift counter, replacing the fixed serial-in/serial-out register. It holds, shifts right, shifts left or parallel-loads a WIDTH-bit word each clock, exposes both serial ends and the full parallel word, and counts shifts since the last load so serializer/deserializer logic can tell when a complete word has passed.

---
 rtl/univ_shift_reg.sv | 93 +++++++++
 tb/tb_univ_shift_reg.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register.
// Each clock it can hold, shift right, shift left or parallel-load.
// A saturating counter reports how many shifts have happened since the last
// load or reset.
// Optional feature: define USR_ROTATE_EN so that rot=1 turns the shifts into
// rotates. Without the macro the rot port is present but ignored.
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CW      = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  input  logic [WIDTH-1:0] d,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CW-1:0]    shift_cnt,
  output logic             full
);

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_SHR  = 2'b01;
  localparam logic [1:0] M_SHL  = 2'b10;
  localparam logic [1:0] M_LOAD = 2'b11;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    cnt_inc;
  logic             fill_msb;  // bit entering q[WIDTH-1] on a right shift
  logic             fill_lsb;  // bit entering q[0] on a left shift

`ifdef USR_ROTATE_EN
  // In rotate mode the bit that falls off one end wraps around to the other.
  assign fill_msb = rot ? q[0]       : sin_msb;
  assign fill_lsb = rot ? q[WIDTH-1] : sin_lsb;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign fill_msb   = sin_msb;
  assign fill_lsb   = sin_lsb;
`endif

  assign full     = (shift_cnt == CNT_MAX);
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

  // The counter stops at WIDTH and never wraps.
  assign cnt_inc = full ? shift_cnt : shift_cnt + CW'(1);

  // Next register word and next count, selected by mode.
  always_comb begin
    q_nxt   = q;
    cnt_nxt = shift_cnt;
    if (en) begin
      case (mode)
        M_SHR: begin
          q_nxt   = {fill_msb, q[WIDTH-1:1]};
          cnt_nxt = cnt_inc;
        end
        M_SHL: begin
          q_nxt   = {q[WIDTH-2:0], fill_lsb};
          cnt_nxt = cnt_inc;
        end
        M_LOAD: begin
          q_nxt   = d;
          cnt_nxt = '0;
        end
        M_HOLD:  ;
        default: ;
      endcase
    end
  end

  // Register the word and the count. Reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q         <= RST_VAL;
      shift_cnt <= '0;
    end else begin
      q         <= q_nxt;
      shift_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Testbench for univ_shift_reg with WIDTH=8 and RST_VAL=8'hA5.
// A reference model computes the expected state for each driven cycle.
// That expected state is pushed to a queue before the clock edge, then
// popped and compared after the edge.
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);
  localparam logic [W-1:0] RV = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic          sin_msb;
  logic          sin_lsb;
  logic [W-1:0]  d;
  logic          rot;
  logic [W-1:0]  q;
  logic          sout_msb;
  logic          sout_lsb;
  logic [CW-1:0] shift_cnt;
  logic          full;

  univ_shift_reg #(.WIDTH(W), .RST_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .d(d), .rot(rot),
    .q(q), .sout_msb(sout_msb), .sout_lsb(sout_lsb),
    .shift_cnt(shift_cnt), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    int           cnt;
  } exp_t;

  exp_t sb[$];
  logic [W-1:0] mq;
  int           mcnt;
  int nerr = 0;
  int nchk = 0;

`ifdef USR_ROTATE_EN
  localparam bit ROT_BUILD = 1'b1;
`else
  localparam bit ROT_BUILD = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, then check after the edge.
  task automatic step(input logic e, input logic [1:0] m, input logic smsb,
                      input logic slsb, input logic [W-1:0] dd, input logic r);
    exp_t x;
    logic fm, fl;
    en = e; mode = m; sin_msb = smsb; sin_lsb = slsb; d = dd; rot = r;
    fm = (ROT_BUILD && r) ? mq[0]   : smsb;
    fl = (ROT_BUILD && r) ? mq[W-1] : slsb;
    if (e) begin
      case (m)
        2'b01: begin
          mq   = {fm, mq[W-1:1]};
          mcnt = (mcnt < W) ? mcnt + 1 : W;
        end
        2'b10: begin
          mq   = {mq[W-2:0], fl};
          mcnt = (mcnt < W) ? mcnt + 1 : W;
        end
        2'b11: begin
          mq   = dd;
          mcnt = 0;
        end
        default: ;
      endcase
    end
    x.q = mq; x.cnt = mcnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      x = sb.pop_front();
      chk("q", 64'(q), 64'(x.q));
      chk("cnt", 64'(shift_cnt), 64'(x.cnt));
      chk("full", 64'(full), 64'(x.cnt == W));
      chk("sout_msb", 64'(sout_msb), 64'(x.q[W-1]));
      chk("sout_lsb", 64'(sout_lsb), 64'(x.q[0]));
    end
  endtask

  logic [3:0] siso_pat;
  logic [3:0] siso_exp;

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; sin_msb = 1'b0; sin_lsb = 1'b0;
    d = '0; rot = 1'b0;
    mq = RV; mcnt = 0;
    #12;
    chk("rst_q", 64'(q), 64'(RV));
    chk("rst_cnt", 64'(shift_cnt), 0);
    chk("rst_full", 64'(full), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Load, then shift right 4 times with zero fill.
    step(1, 2'b11, 0, 0, 8'hF0, 0);
    for (int i = 0; i < 4; i++) step(1, 2'b01, 0, 0, '0, 0);
    chk("shr_q", 64'(q), 64'h0F);
    chk("shr_cnt", 64'(shift_cnt), 4);
    chk("shr_full", 64'(full), 0);
    chk("shr_sout_lsb", 64'(sout_lsb), 1);

    // Assert reset asynchronously in the middle of shifting.
    step(1, 2'b10, 0, 1, '0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_q", 64'(q), 64'(RV));
    chk("arst_cnt", 64'(shift_cnt), 0);
    chk("arst_full", 64'(full), 0);
    mq = RV; mcnt = 0;
    #2 rst = 1'b0;

    // SISO: the serial input pattern should appear on sout_msb W cycles later.
    step(1, 2'b11, 0, 0, 8'h00, 0);
    siso_pat = 4'b1110;  // bits presented in order: 1,1,1,0
    siso_exp = 4'b1110;
    for (int k = 1; k <= 12; k++) begin
      step(1, 2'b10, 0, (k <= 4) ? siso_pat[4-k] : 1'b0, '0, 0);
      if (k == 7) chk("siso_full7", 64'(full), 0);
      if (k == 8) chk("siso_full8", 64'(full), 1);
      if (k >= 8 && k <= 11) chk($sformatf("siso_out%0d", k), 64'(sout_msb), 64'(siso_exp[11-k]));
    end
    chk("siso_full12", 64'(full), 1);
    chk("siso_cnt12", 64'(shift_cnt), W);

    // With en low, mode is ignored and everything holds.
    step(1, 2'b11, 0, 0, 8'h3C, 0);
    for (int i = 0; i < 5; i++) step(0, 2'b01, 1, 1, 8'hFF, 0);
    step(1, 2'b00, 1, 1, 8'hFF, 0);
    chk("hold_q", 64'(q), 64'h3C);
    chk("hold_cnt", 64'(shift_cnt), 0);

    // A reload in the middle of a count clears the counter.
    for (int i = 0; i < 5; i++) step(1, (i % 2) ? 2'b01 : 2'b10, 1, 0, '0, 0);
    chk("mid_cnt5", 64'(shift_cnt), 5);
    step(1, 2'b11, 0, 0, 8'h81, 0);
    chk("reload_q", 64'(q), 64'h81);
    chk("reload_cnt", 64'(shift_cnt), 0);
    chk("reload_full", 64'(full), 0);

    // Rotate when the macro is defined, plain shift otherwise.
    step(1, 2'b10, 0, 0, '0, 1);
    chk("rotl_q", 64'(q), ROT_BUILD ? 64'h03 : 64'h02);
    step(1, 2'b11, 0, 0, 8'h81, 1);
    step(1, 2'b01, 0, 0, '0, 1);
    chk("rotr_q", 64'(q), ROT_BUILD ? 64'hC0 : 64'h40);
    chk("rotr_cnt", 64'(shift_cnt), 1);

    // Random traffic, checked against the model.
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 7) != 0), 2'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), 1'($urandom));

    chk("sb_drained", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
